// File: rtl/hit_uart_readout.sv
// hit_uart_readout: pops 8-bit timing words from the hit FIFO and sends each
// one on an 8N1 (or 8E1) UART line. It also counts the completed frames.
//
// Ports:
//   SYSCLK              system clock, rising edge
//   RESET_N             asynchronous active-low reset
//   fifo_data_available hit FIFO non-empty
//   fifo_dout[7:0]      FIFO read data, valid the cycle after read_fifo
//   read_fifo           one-cycle pop strobe, decoded from the POP state
//   tx_enable           host permission to start a new frame (sampled in IDLE)
//   UART_TX             registered serial line, idle high
//   tx_busy             high whenever the FSM is not IDLE
//   words_sent[15:0]    count of completed frames, wraps
module hit_uart_readout #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        fifo_data_available,
  input  logic [7:0]  fifo_dout,
  input  logic        tx_enable,
  output logic        read_fifo,
  output logic        UART_TX,
  output logic        tx_busy,
  output logic [15:0] words_sent
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_par, w_par_nxt;
  logic             r_tx, w_tx_nxt;
  logic [15:0]      r_words, w_words_nxt;
  logic             w_last;

  // Last cycle of the current bit period; the counter counts down to zero.
  assign w_last = (r_cnt == '0);

  // Next-state logic. UART_TX is registered, so each transition also sets
  // the line level for the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;
    w_words_nxt = r_words;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (tx_enable && fifo_data_available) begin
          w_state_nxt = S_POP;
        end
      end

      S_POP: begin
        w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        w_shift_nxt = fifo_dout;
        w_par_nxt   = ^fifo_dout;
        w_cnt_nxt   = CNT_RELOAD;
        w_tx_nxt    = 1'b0;
        w_state_nxt = S_START;
      end

      S_START: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt   = CNT_RELOAD;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt = CNT_RELOAD;
          if (r_bit == 3'd7) begin
            if (PARITY_EN != 0) begin
              w_tx_nxt    = r_par;
              w_state_nxt = S_PARITY;
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = S_STOP;
            end
          end else begin
            // Shift right so the next bit to send is always r_shift[0].
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end

      S_PARITY: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt   = CNT_RELOAD;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (!w_last) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_words_nxt = r_words + 16'd1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the frame and raises the line.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_words <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_words <= w_words_nxt;
    end
  end

  assign read_fifo  = (r_state == S_POP);
  assign tx_busy    = (r_state != S_IDLE);
  assign UART_TX    = r_tx;
  assign words_sent = r_words;

endmodule

// File: tb/tb_hit_uart_readout.sv
// Bench for hit_uart_readout: channel 0 runs 8N1, channel 1 runs 8E1, both
// with 4 clocks per bit. A timeline model predicts every output each cycle;
// directed literal frames pin the model.
module tb_hit_uart_readout;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       en, avail, rf, tx, busy;
  logic [1:0][7:0]  dout;
  logic [1:0][15:0] words;

  // Bench-side FIFO contents per channel
  logic [7:0] fmem [2][32];
  int fwr [2];
  int frd [2];
  int pulses [2];

  int checks = 0;
  int failures = 0;

  // Timeline model state
  logic        m_rst;
  logic        m_req [2];
  logic        m_act [2];
  int          m_k [2];
  int          m_rd [2];
  int          m_nb [2];
  logic [10:0] m_bits [2];
  logic [15:0] m_words [2];

  logic [10:0] v;

  hit_uart_readout #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .SYSCLK(clk), .RESET_N(rst_n), .fifo_data_available(avail[0]),
    .fifo_dout(dout[0]), .tx_enable(en[0]), .read_fifo(rf[0]),
    .UART_TX(tx[0]), .tx_busy(busy[0]), .words_sent(words[0]));

  hit_uart_readout #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .SYSCLK(clk), .RESET_N(rst_n), .fifo_data_available(avail[1]),
    .fifo_dout(dout[1]), .tx_enable(en[1]), .read_fifo(rf[1]),
    .UART_TX(tx[1]), .tx_busy(busy[1]), .words_sent(words[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Line levels of one frame, index 0 = start bit
  function automatic logic [10:0] frame_bits(input logic [7:0] w, input bit par);
    logic [10:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = w;
    if (par) b[9] = ^w;
    return b;
  endfunction

  task automatic push(input int c, input logic [7:0] w);
    fmem[c][fwr[c]] = w;
    fwr[c] = fwr[c] + 1;
  endtask

  // Standard-read FIFO: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rf[c]) begin
        dout[c]   <= fmem[c][frd[c]];
        frd[c]    <= frd[c] + 1;
        pulses[c] <= pulses[c] + 1;
      end
      avail[c] <= (fwr[c] > frd[c] + (rf[c] ? 1 : 0));
    end
  end

  // Model: a request seen at edge E gives pop after E, line low from E+2 for
  // nb bit periods, then idle; the next request can be seen one edge later.
  always @(posedge clk) begin
    m_rst    = rst_n;
    m_req[0] = en[0] && avail[0];
    m_req[1] = en[1] && avail[1];
    #1;
    for (int c = 0; c < 2; c++) begin
      logic e_rf, e_busy, e_tx;
      if (!m_rst) begin
        m_act[c]   = 1'b0;
        m_words[c] = 16'd0;
      end else if (m_act[c]) begin
        if (m_k[c] + 1 == m_nb[c] * CPB + 2) begin
          m_act[c]   = 1'b0;
          m_words[c] = m_words[c] + 16'd1;
        end else begin
          m_k[c] = m_k[c] + 1;
        end
      end else if (m_req[c] === 1'b1) begin
        m_act[c]  = 1'b1;
        m_k[c]    = 0;
        m_nb[c]   = (c == 1) ? 11 : 10;
        m_bits[c] = frame_bits(fmem[c][m_rd[c]], c == 1);
        m_rd[c]   = m_rd[c] + 1;
      end
      e_rf   = m_act[c] && (m_k[c] == 0);
      e_busy = m_act[c];
      e_tx   = (!m_act[c] || m_k[c] < 2) ? 1'b1 : m_bits[c][(m_k[c] - 2) / CPB];
      chk($sformatf("ch%0d UART_TX", c), 32'(tx[c]), 32'(e_tx));
      chk($sformatf("ch%0d read_fifo", c), 32'(rf[c]), 32'(e_rf));
      chk($sformatf("ch%0d tx_busy", c), 32'(busy[c]), 32'(e_busy));
      chk($sformatf("ch%0d words_sent", c), 32'(words[c]), 32'(m_words[c]));
    end
  end

  // Returns at the first falling clock edge inside a start bit
  task automatic wait_start(input int c);
    int n = 0;
    while (tx[c] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ch%0d start bit seen", c), 32'(tx[c]), 32'd0);
  endtask

  task automatic capture(input int c, input int nb, output logic [10:0] bits);
    bits = '1;
    wait_start(c);
    bits[0] = tx[c];
    for (int b = 1; b < nb; b++) begin
      repeat (CPB) @(negedge clk);
      bits[b] = tx[c];
    end
  endtask

  task automatic wait_idle(input int c, input int budget);
    int n = 0;
    while (busy[c] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ch%0d idle reached", c), 32'(busy[c]), 32'd0);
  endtask

  task automatic wait_words(input int c, input logic [15:0] target, input int budget);
    int n = 0;
    while (words[c] !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ch%0d words reached", c), 32'(words[c]), 32'(target));
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en    = 2'b11;
    push(0, 8'h2D);
    repeat (5) @(negedge clk);
    chk("reset UART_TX", 32'(tx[0]), 32'd1);
    chk("reset read_fifo", 32'(rf[0]), 32'd0);
    chk("reset tx_busy", 32'(busy[0]), 32'd0);
    chk("reset words_sent", 32'(words[0]), 32'd0);
    rst_n = 1'b1;

    // Single word 0x2D
    capture(0, 10, v);
    chk("frame 0x2D", 32'(v[9:0]), 32'(10'b1001011010));
    wait_idle(0, 50);
    chk("single words_sent", 32'(words[0]), 32'd1);
    chk("single pops", 32'(pulses[0]), 32'd1);

    // Back-to-back
    push(0, 8'h00);
    push(0, 8'h3F);
    push(0, 8'h17);
    capture(0, 10, v);
    chk("frame 0x00", 32'(v[9:0]), 32'(10'b1000000000));
    capture(0, 10, v);
    chk("frame 0x3F", 32'(v[9:0]), 32'(10'b1001111110));
    capture(0, 10, v);
    chk("frame 0x17", 32'(v[9:0]), 32'(10'b1000101110));
    wait_idle(0, 50);
    chk("b2b words_sent", 32'(words[0]), 32'd4);
    chk("b2b pops", 32'(pulses[0]), 32'd4);

    // Parity channel
    push(1, 8'h07);
    push(1, 8'h03);
    capture(1, 11, v);
    chk("frame 0x07 8E1", 32'(v), 32'(11'b11000001110));
    chk("parity 0x07", 32'(v[9]), 32'd1);
    capture(1, 11, v);
    chk("frame 0x03 8E1", 32'(v), 32'(11'b10000000110));
    chk("parity 0x03", 32'(v[9]), 32'd0);
    wait_idle(1, 60);
    chk("parity words_sent", 32'(words[1]), 32'd2);

    // Flow control: drop enable mid-frame
    push(0, 8'h11);
    push(0, 8'h22);
    wait_start(0);
    repeat (8) @(negedge clk);
    en[0] = 1'b0;
    wait_idle(0, 60);
    repeat (20) @(negedge clk);
    chk("flow pops held", 32'(pulses[0]), 32'd5);
    chk("flow words_sent", 32'(words[0]), 32'd5);
    chk("flow busy low", 32'(busy[0]), 32'd0);
    en[0] = 1'b1;
    wait_words(0, 16'd6, 80);
    chk("flow pops resumed", 32'(pulses[0]), 32'd6);

    // Reset during data bit 3 of 0x55
    repeat (4) @(negedge clk);
    push(0, 8'h55);
    wait_start(0);
    repeat (17) @(negedge clk);
    chk("bit3 level before reset", 32'(tx[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midframe reset UART_TX", 32'(tx[0]), 32'd1);
    chk("midframe reset words_sent", 32'(words[0]), 32'd0);
    chk("midframe reset tx_busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Wrap of words_sent
    force dut0.r_words = 16'hFFFF;
    m_words[0] = 16'hFFFF;
    @(negedge clk);
    release dut0.r_words;
    @(negedge clk);
    chk("preset words_sent", 32'(words[0]), 32'h0000FFFF);
    push(0, 8'h5A);
    wait_words(0, 16'h0000, 80);
    chk("wrap words_sent", 32'(words[0]), 32'd0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_uart_readout.md
Name: hit_uart_readout

Overview:
- Drains 8-bit timing words from the hit FIFO and serialises each one on an 8N1 UART line to the host.
- Each timing word is {2'b00, coarse_time[2:0], fine_time[2:0]}.
- Sits on the read side of the hit FIFO, in the SYSCLK domain. It is the consumer of fifo_data_available, read_fifo and fifo_dout.
- Also keeps a count of the words transmitted, for host-side loss checks.

Parameters:
- CLKS_PER_BIT, 868, SYSCLK cycles per UART bit period (100 MHz / 115200). Legal range is 2 or more.
- PARITY_EN, 0, when 1 an even-parity bit is inserted after the data bits (8E1 framing).

Ports:
- SYSCLK  in  1  system clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- fifo_data_available  in  1  hit FIFO is non-empty.
- fifo_dout  in  8  hit FIFO read data; valid one cycle after read_fifo (standard read, not first-word-fall-through).
- read_fifo  out  1  FIFO read enable; one-cycle pulse per word.
- tx_enable  in  1  host permission to start new frames.
- UART_TX  out  1  serial line; idle high.
- tx_busy  out  1  high whenever the state is not IDLE.
- words_sent  out  16  count of completed frames; wraps.

Behaviour:
- Interface: one clock, SYSCLK. Reset RESET_N is asynchronous and active-low.
- Reset values (while RESET_N is low):
  - UART_TX=1, read_fifo=0, tx_busy=0, words_sent=0, state=IDLE.
  - Bit-period counter, bit index and shift register are cleared.
- Reset mid-frame: the frame is abandoned and UART_TX returns high immediately (asynchronously). A partially sent word is lost and not counted.
- UART_TX is a registered output. read_fifo is decoded directly from state POP.
- State machine:
  - IDLE: if tx_enable && fifo_data_available, go to POP; otherwise stay.
  - POP: read_fifo=1 for exactly this one cycle; go to LOAD.
  - LOAD: capture fifo_dout into the shift register; compute parity = ^fifo_dout; go to START.
  - START: UART_TX=0 for CLKS_PER_BIT cycles; then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; after bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: UART_TX = even-parity bit for CLKS_PER_BIT cycles; then STOP.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles; on the final cycle increment words_sent (16-bit wrap 0xFFFF->0x0000) and go to IDLE.
- Timing:
  - If IDLE samples the request at edge E, UART_TX falls at edge E+2.
  - Frame length is 10 bit periods (11 with parity).
  - Back-to-back words: exactly 3 SYSCLK cycles of extra idle-high line between the end of STOP and the next start bit.
- tx_enable is sampled only in IDLE. Deasserting it mid-frame lets the current frame complete, and no further pop is made.
- Exactly one read_fifo pulse per frame. The block never pops when fifo_data_available=0. The FIFO cannot go empty between IDLE and POP because this block is its only reader.
- Bit-period counter width is $clog2(CLKS_PER_BIT). The counter reloads at every bit boundary, and bit boundaries are exact: no cumulative drift.

Test Plan:
- Reset: hold RESET_N=0 with fifo_data_available=1 and tx_enable=1 -> UART_TX=1, read_fifo=0, tx_busy=0, words_sent=0 throughout.
- Single word (CLKS_PER_BIT=4, PARITY_EN=0): FIFO holds 0x2D, tx_enable=1.
  - read_fifo is high for exactly 1 cycle.
  - UART_TX sequence is 0,1,0,1,1,0,1,0,0,1, each bit lasting 4 cycles.
  - words_sent=1 and tx_busy=0 afterwards.
- Back-to-back (CLKS_PER_BIT=4): FIFO holds 0x00, 0x3F, 0x17.
  - Three frames are sent in order, with 3 extra idle-high cycles between stop and start.
  - Exactly 3 read_fifo pulses; words_sent=3.
- Parity (PARITY_EN=1, CLKS_PER_BIT=4):
  - Word 0x07 -> parity bit 1; frame is 11 bit periods.
  - Word 0x03 -> parity bit 0.
- Flow control:
  - Drop tx_enable during DATA of word 1 while the FIFO holds 2 words -> word 1 completes, no second pop, tx_busy falls.
  - Re-raise tx_enable -> word 2 is sent.
- Reset mid-frame and wrap:
  - Assert RESET_N=0 during DATA bit 3 -> UART_TX goes high immediately and words_sent=0.
  - Separately, force words_sent to 0xFFFF and send one word -> words_sent=0x0000.
